// File: rtl/local_mem_rmw_unit.sv
// Local-memory sub-unit: registered-output RAM bridge with in-order responses,
// hardware AMO read-modify-write and an optional LR/SC reservation (LOCAL_MEM_LRSC_EN).
module local_mem_rmw_unit #(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_WIDTH   = 30,
    parameter int INCLUDE_AMO  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  new_request,
    input  logic [31:0]           addr,
    input  logic                  re,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [31:0]           data_in,
    input  logic [4:0]            amo_op,
    input  logic                  is_rmw,
    input  logic                  is_lr,
    input  logic                  is_sc,
    output logic                  ready,
    output logic                  data_valid,
    output logic [31:0]           data_out,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_data_in,
    input  logic [31:0]           mem_data_out
);
    localparam bit AMO_EN = (INCLUDE_AMO != 0);

    typedef enum logic [1:0] {IDLE, WAIT, WRITE} state_t;

    state_t                  state, state_next;
    logic [1:0]              cnt, cnt_next;
    logic [ADDR_WIDTH-1:0]   word_addr, rmw_addr;
    logic [31:0]             rs2, amo_result;
    logic [4:0]              rmw_op;
    logic                    accept, rmw_start, sc_ok, sc_status;
    logic [READ_LATENCY-1:0] vld_p, sc_p, status_p;
    logic                    unused_bits;

    assign word_addr   = addr[ADDR_WIDTH+1:2];
    assign ready       = (state == IDLE);
    assign accept      = new_request & ready;
    assign rmw_start   = accept & is_rmw & AMO_EN;
    assign unused_bits = ^{addr, is_lr};

    function automatic logic [31:0] amo_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (op)
            5'b00000: amo_alu = a + b;
            5'b00100: amo_alu = a ^ b;
            5'b01000: amo_alu = a | b;
            5'b01100: amo_alu = a & b;
            5'b10000: amo_alu = (sa < sb) ? a : b;
            5'b10100: amo_alu = (sa > sb) ? a : b;
            5'b11000: amo_alu = (a < b) ? a : b;
            5'b11100: amo_alu = (a > b) ? a : b;
            default:  amo_alu = b;
        endcase
    endfunction

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        mem_en      = 1'b0;
        mem_addr    = word_addr;
        mem_be      = 4'h0;
        mem_data_in = data_in;
        sc_status   = 1'b0;
        case (state)
            IDLE: begin
                if (new_request) begin
                    if (rmw_start) begin
                        mem_en     = 1'b1;
                        state_next = WAIT;
                        cnt_next   = 2'(READ_LATENCY - 1);
                    end else if (is_sc) begin
                        mem_en    = sc_ok;
                        mem_be    = sc_ok ? be : 4'h0;
                        sc_status = ~sc_ok;
                    end else begin
                        mem_en = 1'b1;
                        mem_be = we ? be : 4'h0;
                    end
                end
            end
            WAIT: begin
                if (cnt == 2'd0) state_next = WRITE;
                else             cnt_next   = cnt - 2'd1;
            end
            WRITE: begin
                mem_en      = 1'b1;
                mem_addr    = rmw_addr;
                mem_be      = 4'hF;
                mem_data_in = amo_result;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // RMW operands are captured at accept; the ALU result on the read-return cycle
    always_ff @(posedge clk) begin
        if (rmw_start) begin
            rmw_addr <= word_addr;
            rs2      <= data_in;
            rmw_op   <= amo_op;
        end
        if (state == WAIT && cnt == 2'd0) amo_result <= amo_alu(rmw_op, mem_data_out, rs2);
    end

`ifdef LOCAL_MEM_LRSC_EN
    logic                  resv_valid;
    logic [ADDR_WIDTH-1:0] resv_addr;

    assign sc_ok = resv_valid && (resv_addr == word_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resv_valid <= 1'b0;
            resv_addr  <= '0;
        end else if (state == WRITE) begin
            if (resv_addr == rmw_addr) resv_valid <= 1'b0;
        end else if (accept && !rmw_start) begin
            if (is_sc) begin
                resv_valid <= 1'b0;
            end else if (is_lr) begin
                resv_valid <= 1'b1;
                resv_addr  <= word_addr;
            end else if (we && be != 4'h0 && sc_ok) begin
                resv_valid <= 1'b0;
            end
        end
    end
`else
    assign sc_ok = 1'b1;
`endif

    // Response pipeline: depth matches RAM read latency so SC status and load data stay ordered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= accept & re;
            for (int i = 1; i < READ_LATENCY; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        sc_p[0]     <= accept & is_sc & ~rmw_start;
        status_p[0] <= sc_status;
        for (int i = 1; i < READ_LATENCY; i++) begin
            sc_p[i]     <= sc_p[i-1];
            status_p[i] <= status_p[i-1];
        end
    end

    assign data_valid = vld_p[READ_LATENCY-1];
    assign data_out   = sc_p[READ_LATENCY-1] ? {31'b0, status_p[READ_LATENCY-1]} : mem_data_out;

endmodule

// File: tb/tb_local_mem_rmw_unit.sv
// Directed bench for local_mem_rmw_unit with a behavioural latency-matched RAM model.
module tb_local_mem_rmw_unit;
    localparam int RL = 3;
    localparam int AW = 30;
    localparam logic [4:0] OP_ADD = 5'b00000, OP_SWAP = 5'b00001, OP_MAX = 5'b10100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          new_request, re, we, is_rmw, is_lr, is_sc;
    logic [31:0]   addr, data_in;
    logic [3:0]    be;
    logic [4:0]    amo_op;
    logic          ready, data_valid, mem_en;
    logic [31:0]   data_out, mem_data_in, mem_data_out;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    int            n_tests, n_fail;

    always #5 clk = ~clk;

    local_mem_rmw_unit #(.READ_LATENCY(RL), .ADDR_WIDTH(AW), .INCLUDE_AMO(1)) dut (
        .clk(clk), .rst_n(rst_n), .new_request(new_request), .addr(addr), .re(re), .we(we),
        .be(be), .data_in(data_in), .amo_op(amo_op), .is_rmw(is_rmw), .is_lr(is_lr),
        .is_sc(is_sc), .ready(ready), .data_valid(data_valid), .data_out(data_out),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_be(mem_be), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out)
    );

    logic [31:0] ram [256];
    logic [31:0] rd_p [RL];
    logic        unused_tb;
    assign unused_tb    = ^mem_addr;
    assign mem_data_out = rd_p[RL-1];

    always @(posedge clk) begin
        if (mem_en && mem_be != 4'h0)
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) ram[mem_addr[7:0]][8*b +: 8] <= mem_data_in[8*b +: 8];
        rd_p[0] <= ram[mem_addr[7:0]];
        for (int i = 1; i < RL; i++) rd_p[i] <= rd_p[i-1];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic clear_inputs();
        new_request = 1'b0; re = 1'b0; we = 1'b0; is_rmw = 1'b0; is_lr = 1'b0; is_sc = 1'b0;
        addr = '0; data_in = '0; be = '0; amo_op = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                       input logic r, input logic w, input logic rmw, input logic lr,
                       input logic sc, input logic [4:0] op);
        new_request = 1'b1; addr = a; data_in = d; be = b; re = r; we = w;
        is_rmw = rmw; is_lr = lr; is_sc = sc; amo_op = op;
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        req(a, d, b, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic load(input logic [31:0] a);
        req(a, 32'd0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic amo(input logic [31:0] a, input logic [31:0] d, input logic [4:0] op,
                       input logic r);
        req(a, d, 4'h0, r, 1'b0, 1'b1, 1'b0, 1'b0, op);
    endtask

    // Response must appear exactly RL cycles after the request issued in the current cycle
    task automatic expect_resp(input string tag, input logic [31:0] exp);
        for (int i = 1; i < RL; i++) begin
            next_cycle();
            check({tag, "_early"}, 32'(data_valid), 32'd0);
        end
        next_cycle();
        check({tag, "_vld"}, 32'(data_valid), 32'd1);
        check({tag, "_data"}, data_out, exp);
        next_cycle();
        check({tag, "_end"}, 32'(data_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_dvld", 32'(data_valid), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        rst_n = 1'b1;
        next_cycle();

        store(32'h40, 32'hDEADBEEF, 4'hF);
        check("st_en", 32'(mem_en), 32'd1);
        check("st_be", 32'(mem_be), 32'hF);
        next_cycle();
        load(32'h40);
        check("ld_be", 32'(mem_be), 32'd0);
        expect_resp("ld40", 32'hDEADBEEF);

        store(32'h0, 32'd1, 4'hF); next_cycle();
        store(32'h4, 32'd2, 4'hF); next_cycle();
        store(32'h8, 32'd3, 4'hF); next_cycle();
        load(32'h0); next_cycle();
        load(32'h4); next_cycle();
        load(32'h8); next_cycle();
        check("b2b0_vld", 32'(data_valid), 32'd1); check("b2b0_data", data_out, 32'd1);
        next_cycle();
        check("b2b1_vld", 32'(data_valid), 32'd1); check("b2b1_data", data_out, 32'd2);
        next_cycle();
        check("b2b2_vld", 32'(data_valid), 32'd1); check("b2b2_data", data_out, 32'd3);
        next_cycle();
        check("b2b_end", 32'(data_valid), 32'd0);

        store(32'h8, 32'hAABBCCDD, 4'b0011); next_cycle();
        load(32'h8);
        expect_resp("partial_be", 32'h0000CCDD);

        store(32'h100, 32'd10, 4'hF); next_cycle();
        amo(32'h100, 32'd5, OP_ADD, 1'b1);
        check("add_acc_ready", 32'(ready), 32'd1);
        check("add_rd_en", 32'(mem_en), 32'd1);
        check("add_rd_be", 32'(mem_be), 32'd0);
        next_cycle();
        check("add_t1_ready", 32'(ready), 32'd0);
        check("add_t1_dvld", 32'(data_valid), 32'd0);
        next_cycle();
        check("add_t2_ready", 32'(ready), 32'd0);
        next_cycle();
        check("add_t3_ready", 32'(ready), 32'd0);
        check("add_t3_dvld", 32'(data_valid), 32'd1);
        check("add_t3_old", data_out, 32'd10);
        next_cycle();
        check("add_t4_ready", 32'(ready), 32'd0);
        check("add_wr_en", 32'(mem_en), 32'd1);
        check("add_wr_be", 32'(mem_be), 32'hF);
        check("add_wr_data", mem_data_in, 32'd15);
        check("add_wr_addr", 32'(mem_addr), 32'd64);
        check("add_t4_dvld", 32'(data_valid), 32'd0);
        next_cycle();
        check("add_t5_ready", 32'(ready), 32'd1);
        load(32'h100);
        expect_resp("add_reload", 32'd15);

        store(32'h108, 32'hFFFFFFFD, 4'hF); next_cycle();
        amo(32'h108, 32'd2, OP_MAX, 1'b1);
        expect_resp("max_old", 32'hFFFFFFFD);
        next_cycle();
        load(32'h108);
        expect_resp("max_reload", 32'd2);

        store(32'h10C, 32'h11, 4'hF); next_cycle();
        amo(32'h10C, 32'h55, OP_SWAP, 1'b0);
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            check("swap_x0_dvld", 32'(data_valid), 32'd0);
        end
        check("swap_x0_mem", ram[67], 32'h55);
        check("swap_x0_ready", 32'(ready), 32'd1);

`ifdef LOCAL_MEM_LRSC_EN
        store(32'h80, 32'h99, 4'hF); next_cycle();
        req(32'h80, 32'd0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        expect_resp("lr1", 32'h99);
        req(32'h80, 32'd7, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        check("sc1_en", 32'(mem_en), 32'd1);
        expect_resp("sc1_status", 32'd0);
        check("sc1_mem", ram[32], 32'd7);
        req(32'h80, 32'd9, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        check("sc2_en", 32'(mem_en), 32'd0);
        expect_resp("sc2_status", 32'd1);
        check("sc2_mem", ram[32], 32'd7);
        req(32'h80, 32'd0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        expect_resp("lr2", 32'd7);
        store(32'h80, 32'h22, 4'hF); next_cycle();
        req(32'h80, 32'h33, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        expect_resp("sc3_status", 32'd1);
        check("sc3_mem", ram[32], 32'h22);
        req(32'h80, 32'd0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        expect_resp("lr3", 32'h22);
        amo(32'h80, 32'd1, OP_ADD, 1'b0);
        repeat (5) next_cycle();
        req(32'h80, 32'h44, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        expect_resp("sc4_status", 32'd1);
        check("sc4_mem", ram[32], 32'h23);
`else
        req(32'h80, 32'd7, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        check("sc_plain_en", 32'(mem_en), 32'd1);
        expect_resp("sc_plain_status", 32'd0);
        check("sc_plain_mem", ram[32], 32'd7);
`endif

        store(32'h200, 32'h1234, 4'hF); next_cycle();
        amo(32'h200, 32'd1, OP_ADD, 1'b1);
        next_cycle();
        check("abort_wait_ready", 32'(ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_dvld", 32'(data_valid), 32'd0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            check("abort_post_dvld", 32'(data_valid), 32'd0);
        end
        check("abort_mem", ram[128], 32'h1234);
        load(32'h200);
        expect_resp("abort_reload", 32'h1234);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
